// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master: converts a valid/ready command port into one
// AXI4-Lite read or write at a time and returns the result on a response port.
module axi_lite_master #(
  parameter int ADDR_WIDTH     = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  timeout,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  WVALID,
  input  logic                  WREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  input  logic                  RVALID,
  output logic                  RREADY,
  input  logic [DATA_WIDTH-1:0] RDATA
);

  localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] WD_LIMIT = CW'(TIMEOUT_CYCLES);
  localparam bit WD_EN = (TIMEOUT_CYCLES > 0);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_AW_W = 3'd1,
    WR_B    = 3'd2,
    RD_AR   = 3'd3,
    RD_R    = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                state_q;
  logic                  cmd_ready_q;
  logic                  rsp_valid_q;
  logic                  rsp_write_q;
  logic [DATA_WIDTH-1:0] rsp_rdata_q;
  logic                  timeout_q;
  logic                  awvalid_q;
  logic [ADDR_WIDTH-1:0] awaddr_q;
  logic                  wvalid_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  bready_q;
  logic                  arvalid_q;
  logic [ADDR_WIDTH-1:0] araddr_q;
  logic                  rready_q;
  logic [CW-1:0]         wd_cnt_q;
  logic [CW-1:0]         wd_cnt_d;
  logic                  waiting;
  logic                  accept;
  logic                  aw_done;
  logic                  w_done;

  assign waiting = (state_q == WR_AW_W) || (state_q == WR_B) ||
                   (state_q == RD_AR)   || (state_q == RD_R);
  assign accept  = (state_q == IDLE) && cmd_valid && cmd_ready_q;
  // A channel counts as done once its VALID has dropped or it handshakes this cycle.
  assign aw_done = !awvalid_q || AWREADY;
  assign w_done  = !wvalid_q || WREADY;

  always_comb begin
    wd_cnt_d = wd_cnt_q;
    if (WD_EN && waiting && (wd_cnt_q != WD_LIMIT)) begin
      wd_cnt_d = wd_cnt_q + CW'(1);
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else if (accept) begin
      wd_cnt_q  <= '0;
      timeout_q <= 1'b0;
    end else begin
      wd_cnt_q <= wd_cnt_d;
      if (WD_EN && waiting && (wd_cnt_d == WD_LIMIT)) begin
        timeout_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state_q     <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      awvalid_q   <= 1'b0;
      awaddr_q    <= '0;
      wvalid_q    <= 1'b0;
      wdata_q     <= '0;
      bready_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      rready_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (accept) begin
            cmd_ready_q <= 1'b0;
            if (cmd_write) begin
              awaddr_q  <= cmd_addr;
              wdata_q   <= cmd_wdata;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WR_AW_W;
            end else begin
              araddr_q  <= cmd_addr;
              arvalid_q <= 1'b1;
              state_q   <= RD_AR;
            end
          end
        end
        WR_AW_W: begin
          if (awvalid_q && AWREADY) awvalid_q <= 1'b0;
          if (wvalid_q && WREADY)   wvalid_q  <= 1'b0;
          if (aw_done && w_done)    state_q   <= WR_B;
        end
        WR_B: begin
          // BREADY waits one cycle after BVALID so the slave sees BVALID&&!BREADY.
          if (BVALID && bready_q) begin
            bready_q    <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_write_q <= 1'b1;
            rsp_rdata_q <= '0;
            state_q     <= RSP;
          end else if (BVALID) begin
            bready_q <= 1'b1;
          end
        end
        RD_AR: begin
          if (ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RD_R;
          end
        end
        RD_R: begin
          if (RVALID && rready_q) begin
            rready_q    <= 1'b0;
            rsp_rdata_q <= RDATA;
            rsp_write_q <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_write = rsp_write_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = (state_q != IDLE);
  assign timeout   = timeout_q;
  assign AWVALID   = awvalid_q;
  assign AWADDR    = awaddr_q;
  assign WVALID    = wvalid_q;
  assign WDATA     = wdata_q;
  assign BREADY    = bready_q;
  assign ARVALID   = arvalid_q;
  assign ARADDR    = araddr_q;
  assign RREADY    = rready_q;

endmodule
